// File: rtl/spart_brg_if.sv
// SPART I/O bus as seen by the baud rate generator, plus its status and tick outputs.
// The processor side is the master; the generator is the slave.
interface spart_brg_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] databus_in;
   logic       brg_en;
   logic       brg_active;
   logic       lo_pending;

   modport master (
      output iocs, iorw, ioaddr, databus_in,
      input  brg_en, brg_active, lo_pending
   );

   modport slave (
      input  iocs, iorw, ioaddr, databus_in,
      output brg_en, brg_active, lo_pending
   );
endinterface

// File: rtl/spart_brg.sv
// SPART baud rate generator: emits a one-cycle brg_en tick every divisor clocks.
// The divisor is staged low byte first and takes effect on the high-byte write.
module spart_brg #(
   parameter int                   DIV_WIDTH       = 16,
   parameter logic [DIV_WIDTH-1:0] DEFAULT_DIVISOR = DIV_WIDTH'(163)
) (
   input logic         clk,
   input logic         rst,
   spart_brg_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [DIV_WIDTH-1:0] ONE  = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] ZERO = '0;

   state_t               state;
   logic [DIV_WIDTH-1:0] div_active;
   logic [DIV_WIDTH-1:0] count;
   logic [7:0]           div_lo_stage;
   logic                 brg_en_q;
   logic                 lo_pending_q;

   logic                 wr;
   logic                 wr_lo;
   logic                 wr_hi;
   logic [DIV_WIDTH-1:0] new_div;

   assign wr      = bus.iocs & ~bus.iorw;
   assign wr_lo   = wr & (bus.ioaddr == 2'b10);
   assign wr_hi   = wr & (bus.ioaddr == 2'b11);
   assign new_div = DIV_WIDTH'({bus.databus_in, div_lo_stage});

   // A commit takes priority over a terminal count, so no tick escapes on the commit edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_active   <= DEFAULT_DIVISOR;
         div_lo_stage <= DEFAULT_DIVISOR[7:0];
         count        <= DEFAULT_DIVISOR - ONE;
         brg_en_q     <= 1'b0;
         lo_pending_q <= 1'b0;
         state        <= (DEFAULT_DIVISOR == ZERO) ? IDLE : RUN;
      end else if (wr_hi) begin
         div_active   <= new_div;
         lo_pending_q <= 1'b0;
         brg_en_q     <= 1'b0;
         if (new_div != ZERO) begin
            count <= new_div - ONE;
            state <= RUN;
         end else begin
            state <= IDLE;
         end
      end else begin
         if (wr_lo) begin
            div_lo_stage <= bus.databus_in;
            lo_pending_q <= 1'b1;
         end
         case (state)
            IDLE: begin
               brg_en_q <= 1'b0;
            end
            RUN: begin
               if (count == ZERO) begin
                  brg_en_q <= 1'b1;
                  count    <= div_active - ONE;
               end else begin
                  brg_en_q <= 1'b0;
                  count    <= count - ONE;
               end
            end
            default: begin
               brg_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.brg_en     = brg_en_q;
   assign bus.brg_active = (state == RUN);
   assign bus.lo_pending = lo_pending_q;

endmodule

// File: tb/tb_spart_brg.sv
// Bench for spart_brg: directed and random bus writes against an absolute-time tick model,
// with expected outputs queued per edge and checked by an independent monitor.
module tb_spart_brg;

   localparam int DEF = 163;

   typedef struct {
      int edge_n;
      bit en;
      bit act;
      bit pend;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   spart_brg_if bus();

   spart_brg #(.DIV_WIDTH(16), .DEFAULT_DIVISOR(16'd163)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   total  = 0;
   int   bad    = 0;
   int   edge_n = 0;

   // Reference model: period plus the absolute edge number of the next tick.
   int       m_period;
   int       m_next;
   bit       m_run;
   bit       m_pend;
   bit       m_en;
   bit [7:0] m_lo;

   task automatic checkOutput(input exp_t e);
      logic [2:0] got;
      logic [2:0] want;
      got  = {bus.brg_en, bus.brg_active, bus.lo_pending};
      want = {e.en, e.act, e.pend};
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL outputs edge=%0d got en,act,pend=%b want %b", e.edge_n, got, want);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit cs, input bit rw,
                                input bit [1:0] a, input bit [7:0] d);
      exp_t e;
      bit   wr;
      int   nd;
      @(negedge clk);
      rst            = r;
      bus.iocs       = cs;
      bus.iorw       = rw;
      bus.ioaddr     = a;
      bus.databus_in = d;
      edge_n++;
      wr   = cs && !rw;
      m_en = 1'b0;
      if (r) begin
         m_period = DEF;
         m_lo     = 8'(DEF % 256);
         m_pend   = 1'b0;
         m_run    = 1'b1;
         m_next   = edge_n + DEF;
      end else if (wr && a == 2'b11) begin
         nd       = int'(d) * 256 + int'(m_lo);
         m_period = nd;
         m_pend   = 1'b0;
         m_run    = (nd != 0);
         m_next   = edge_n + nd;
      end else begin
         if (wr && a == 2'b10) begin
            m_lo   = d;
            m_pend = 1'b1;
         end
         if (m_run && edge_n == m_next) begin
            m_en   = 1'b1;
            m_next = m_next + m_period;
         end
      end
      e.edge_n = edge_n;
      e.en     = m_en;
      e.act    = m_run;
      e.pend   = m_pend;
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
   endtask

   task automatic writeLo(input bit [7:0] d);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, d);
   endtask

   task automatic writeHi(input bit [7:0] d);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, d);
   endtask

   task automatic commitDiv(input bit [15:0] v);
      writeLo(v[7:0]);
      writeHi(v[15:8]);
   endtask

   // Monitor: checks the DUT shortly after each edge against the queued prediction.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      int guard;
      rst            = 1'b1;
      bus.iocs       = 1'b0;
      bus.iorw       = 1'b0;
      bus.ioaddr     = 2'b00;
      bus.databus_in = 8'h00;

      $display("[TB] reset and free-run at default divisor");
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
      idle(1000);

      $display("[TB] staged low byte then commit divisor 4");
      writeLo(8'h04);
      idle(400);
      writeHi(8'h00);
      idle(40);

      $display("[TB] divisor 1, divisor 0, divisor 2");
      commitDiv(16'h0001);
      idle(20);
      commitDiv(16'h0000);
      idle(200);
      commitDiv(16'h0002);
      idle(20);

      $display("[TB] commit on terminal count");
      commitDiv(16'h0008);
      writeLo(8'h05);
      guard = 0;
      while (m_next != edge_n + 1 && guard < 100) begin
         idle(1);
         guard++;
      end
      if (m_next != edge_n + 1) begin
         total++;
         bad++;
         $display("[TB] FAIL align_terminal_count got guard=%0d required < 100", guard);
      end
      writeHi(8'h00);
      idle(30);

      $display("[TB] ignored bus accesses");
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 8'hFF);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 8'hFF);
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 8'hFF);
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 8'hFF);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'hFF);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 8'hFF);
      idle(20);

      $display("[TB] reset mid-period with pending low byte");
      commitDiv(16'h1234);
      idle(100);
      writeLo(8'hAA);
      idle(10);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
      idle(400);
      writeHi(8'h00);
      idle(400);

      $display("[TB] random bus traffic");
      for (int i = 0; i < 2000; i++) begin
         int sel;
         sel = $urandom_range(0, 39);
         if (sel == 0) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
         end else if (sel < 4) begin
            writeLo(8'($urandom_range(0, 20)));
         end else if (sel < 7) begin
            writeHi(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h00);
         end else if (sel < 10) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         end else begin
            idle(1);
         end
      end
      idle(5);

      #3;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_drain got %0d left required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spart_brg.md
Name: spart_brg

Overview:
- Baud rate generator for the SPART.
- Sits directly upstream of the receive and transmit control blocks and drives their brg_en sample-tick input, which is 16 ticks per bit.
- The processor programs a 16-bit divisor over the SPART I/O bus at ioaddr 2'b10 (low byte, DB_LO) and 2'b11 (high byte, DB_HI).
- The block emits a one-cycle brg_en pulse every DIVISOR clocks.

Parameters:
- DEFAULT_DIVISOR, 16'd163: divisor loaded at reset; 50 MHz / (16 × 19200) ≈ 163.
- DIV_WIDTH, 16: divisor and counter width. Must be ≥ 9.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- iocs  in  1  SPART chip select
- iorw  in  1  1 = read, 0 = write
- ioaddr  in  2  register select
- databus_in  in  8  write data from the processor
- brg_en  out  1  one-cycle sample-tick pulse, registered
- brg_active  out  1  1 when the active divisor is non-zero and ticks are being generated
- lo_pending  out  1  1 when DB_LO has been written since the last DB_HI commit

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On a clk edge with rst=1:
  - div_active = DEFAULT_DIVISOR, div_lo_stage = DEFAULT_DIVISOR[7:0], count = DEFAULT_DIVISOR-1.
  - brg_en = 0, lo_pending = 0, state = RUN (IDLE if DEFAULT_DIVISOR == 0).
  - rst overrides every other input.
- Write decode:
  - wr = iocs & !iorw.
  - wr_lo = wr & ioaddr == 2'b10; wr_hi = wr & ioaddr == 2'b11.
  - Reads and writes to ioaddr 00/01 are ignored.
- wr_lo:
  - div_lo_stage <= databus_in; lo_pending <= 1.
  - div_active is unchanged and ticks continue at the old rate.
- wr_hi (commit):
  - new_div = {databus_in, div_lo_stage}; for DIV_WIDTH > 16, zero-extend the upper bits.
  - div_active <= new_div; lo_pending <= 0; brg_en <= 0 this edge.
  - If new_div != 0: count <= new_div-1 and state <= RUN. Otherwise state <= IDLE.
  - A commit without a preceding wr_lo reuses the last staged low byte.
- State machine:
  - IDLE:
    - brg_en held 0, count held, brg_active = 0.
    - Leaves only on a wr_hi with new_div != 0 (→ RUN).
  - RUN, with brg_active = 1:
    - No commit and count == 0: brg_en <= 1, count <= div_active-1.
    - No commit and count != 0: brg_en <= 0, count <= count-1.
    - wr_hi with new_div == 0 → IDLE.
- Timing:
  - After a commit edge with divisor N ≥ 1, the first brg_en is high N cycles later.
  - It then repeats every N cycles and is exactly one cycle wide.
  - N = 1 gives brg_en high every cycle after the first.
- Simultaneous events:
  - wr_hi in the same cycle that count == 0: the commit wins. No pulse is issued, and the period restarts from the new divisor.
  - wr_lo does not perturb count or brg_en.
- Wrap-around: count never underflows; the reload at 0 is unconditional in RUN.
- Reset mid-period: the count restarts from DEFAULT_DIVISOR-1, lo_pending clears, and a pending low byte is discarded (restaged to the default).

Test Plan:
- Reset with default 163, no writes, run 1000 cycles → brg_en pulses exactly one cycle wide, 163 cycles apart; first pulse 163 cycles after reset release edge; brg_active=1, lo_pending=0.
- Write DB_LO=8'h04 → lo_pending=1, pulse spacing still 163; then write DB_HI=8'h00 → lo_pending=0, first brg_en 4 cycles after commit edge, then every 4.
- Commit divisor 16'h0001 (LO=01, HI=00) → brg_en high every cycle starting 1 cycle after commit; commit 16'h0000 → brg_en stays 0, brg_active=0 for 200 cycles; then commit 16'h0002 → resumes, pulses every 2.
- Assert wr_hi (new divisor 5) on the exact cycle count==0 under divisor 8 → no pulse that edge; next pulse 5 cycles later, spacing 5.
- Writes with iocs=0, with iorw=1, and to ioaddr 00/01 using data 8'hFF → divisor, lo_pending, and pulse spacing unchanged.
- Divisor 0x1234 running, assert rst for one cycle mid-count with lo_pending=1 → lo_pending=0, pulses resume at 163 spacing from the reset edge; a following bare DB_HI=00 commits {00, 163[7:0]} = 163.
